// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA responder.
//   phase_t      - phase tag carried with each transaction
//   resp_state_t - responder state encoding
//   WORD_BYTES   - bytes per memory word (address stride)
package dma_pkg;

    typedef enum logic [1:0] {
        PH_WEIGHTS    = 2'd0,
        PH_DIMENSIONS = 2'd1,
        PH_BIASES     = 2'd2,
        PH_IMAGES     = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } resp_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dma_resp_fifo.sv
// dma_resp_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i/push_data_i write strobe and data (ignored when full)
//   pop_i             consume head (ignored when empty)
//   pop_data_o        current head word
//   full_o, empty_o   occupancy flags
//   count_o           number of stored words
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module dma_resp_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             pop_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dma_responder.sv
// dma_responder: memory-side end of the DMA transaction interface.
// Accepts (addr, len, phase) requests, reads len words from a 1-cycle
// latency memory port and streams them out with valid/ready, then pulses
// next_transaction for one cycle after the final word is accepted.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_en/req_ready               request handshake (ready only in IDLE)
//   req_addr/req_len/req_phase     request fields
//   mem_rd_en/mem_rd_addr          memory read strobe and byte address
//   mem_rd_data                    read data, one cycle after mem_rd_en
//   out_valid/out_ready            output stream handshake
//   out_data/out_last/out_phase    output word, last flag, latched phase
//   busy                           not IDLE
//   next_transaction               one-cycle completion pulse
//   checksum                       only with DMA_RESP_CHECKSUM_EN defined:
//                                  running sum of accepted words
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, req_ready=1
// FETCH | issuing reads while words remain and FIFO credit is free
// DRAIN | all reads issued, waiting for the last word to be accepted
// DONE  | next_transaction=1 for this single cycle
import dma_pkg::*;

module dma_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [1:0]        req_phase,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        out_phase,
    output logic              busy,
    output logic              next_transaction
`ifdef DMA_RESP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    resp_state_t       state_q;
    logic              req_ready_q;
    logic              busy_q;
    logic              next_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    phase_t            phase_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  accepted_q;
    logic              outstanding_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CW:0]       credit_used;
    logic              rd_en;
    logic              push;
    logic              pop;

    // A read is only issued if its data is guaranteed a FIFO slot, counting
    // the word still in flight from the memory.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding_q};
    assign rd_en       = (state_q == FETCH) && (issued_q < len_q)
                         && (credit_used < (CW+1)'(FIFO_DEPTH));

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = base_q + ADDR_W'(issued_q) * ADDR_W'(WORD_BYTES);

    assign push        = outstanding_q & ~fifo_full;
    assign out_valid   = ~fifo_empty;
    assign pop         = out_valid & out_ready;
    assign out_data    = out_valid ? fifo_head : '0;
    assign out_last    = out_valid && (accepted_q == len_q - LEN_W'(1));
    assign out_phase   = phase_q;

    assign req_ready        = req_ready_q;
    assign busy             = busy_q;
    assign next_transaction = next_q;

    dma_resp_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (mem_rd_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            next_q        <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            phase_q       <= PH_WEIGHTS;
            issued_q      <= '0;
            accepted_q    <= '0;
            outstanding_q <= 1'b0;
        end else begin
            outstanding_q <= rd_en;
            if (rd_en) issued_q   <= issued_q + LEN_W'(1);
            if (pop)   accepted_q <= accepted_q + LEN_W'(1);

            case (state_q)
                IDLE: begin
                    if (req_en) begin
                        // Word-align the start address.
                        base_q      <= req_addr & ~ADDR_W'(WORD_BYTES - 1);
                        len_q       <= req_len;
                        phase_q     <= phase_t'(req_phase);
                        issued_q    <= '0;
                        accepted_q  <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_len == '0) begin
                            state_q <= DONE;
                            next_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issued_q == len_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state_q <= DONE;
                        next_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    next_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMA_RESP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (req_en && state_q == IDLE) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + out_data;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dma_responder.sv
`timescale 1ns/1ps
module tb_dma_responder;
    import dma_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_en = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic [1:0]        req_phase = 2'd0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [1:0]        out_phase;
    logic              busy;
    logic              next_transaction;
`ifdef DMA_RESP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    dma_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_en           (req_en),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_phase        (req_phase),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_phase        (out_phase),
        .busy             (busy),
        .next_transaction (next_transaction)
`ifdef DMA_RESP_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  phase;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cnt = 0, acc_cnt = 0, nt_cnt = 0, inflight = 0;
    int first_rd_cyc = 0, last_rd_cyc = 0, last_acc_cyc = 0, nt_cyc = 0, acc_cyc = 0;
    bit arm_first = 1'b0;
    bit stall_prev = 1'b0;
    bit prev_nt = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] csum_at_nt = '0;

    // Memory contents: a few fixed words for the checksum case, otherwise
    // derived from the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h0000_0001;
            32'h0000_0204: return 32'h0000_0002;
            32'h0000_0208: return 32'h0000_0003;
            32'h0000_020C: return 32'hFFFF_FFFF;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : 32'h0;

    // Monitor: reads, output words, stall stability, done pulse.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ea;
        if (rst) begin
            inflight   = 0;
            stall_prev = 1'b0;
            prev_nt    = 1'b0;
        end else begin
            if (mem_rd_en) begin
                chk("read credit", 96'(inflight < FIFO_DEPTH), 96'd1);
                if (addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected read: got addr %0h expected none", mem_rd_addr);
                end else begin
                    ea = addr_q.pop_front();
                    chk("read addr", 96'(mem_rd_addr), 96'(ea));
                end
                if (arm_first) begin
                    first_rd_cyc = cyc;
                    arm_first    = 1'b0;
                end
                last_rd_cyc = cyc;
                rd_cnt++;
                inflight++;
            end
            if (stall_prev) begin
                chk("stall valid held", 96'(out_valid), 96'd1);
                chk("stall data held", 96'(out_data), 96'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected word: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out word", {out_data, out_last, out_phase}, {e.data, e.last, e.phase});
                end
                acc_cnt++;
                inflight--;
                last_acc_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (next_transaction) begin
                chk("done pulse width", 96'(prev_nt), 96'd0);
                nt_cnt++;
                nt_cyc = cyc;
`ifdef DMA_RESP_CHECKSUM_EN
                csum_at_nt = checksum;
`endif
            end
            prev_nt = next_transaction;
        end
    end

    task automatic do_req(input logic [31:0] addr, input int len, input logic [1:0] ph);
        logic [31:0] base;
        logic [31:0] a;
        base = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < len; i++) begin
            a = base + 32'(4 * i);
            addr_q.push_back(a);
            exp_q.push_back('{data: memf(a), last: (i == len - 1), phase: ph});
        end
        @(posedge clk); #1;
        req_en    = 1'b1;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        req_phase = ph;
        @(posedge clk); #1;
        req_en  = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int start_nt, input int budget, input string name);
        int n;
        n = 0;
        while (nt_cnt == start_nt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (nt_cnt == start_nt) begin
            total++; bad++;
            $display("FAIL %s timeout: got no done pulse expected one within %0d cycles", name, budget);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, " done count"}, 96'(nt_cnt), 96'(start_nt + 1));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name,
            {req_ready, busy, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, out_phase, next_transaction},
            {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int nt0, rd0, acc0, n;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset outputs");
        rst = 1'b0;

        // Basic: four back-to-back reads, done one cycle after last accept.
        nt0 = nt_cnt; rd0 = rd_cnt;
        arm_first = 1'b1;
        do_req(32'h0000_0100, 4, PH_WEIGHTS);
        wait_done(nt0, 50, "basic");
        chk("basic first read latency", 96'(first_rd_cyc), 96'(acc_cyc));
        chk("basic reads back-to-back", 96'(last_rd_cyc - first_rd_cyc), 96'd3);
        chk("basic done after last accept", 96'(nt_cyc), 96'(last_acc_cyc + 1));
        chk("basic read count", 96'(rd_cnt - rd0), 96'd4);

        // Zero length: straight to DONE in the cycle after the request is sampled.
        nt0 = nt_cnt; rd0 = rd_cnt; acc0 = acc_cnt;
        do_req(32'h0000_0180, 0, PH_DIMENSIONS);
        wait_done(nt0, 10, "zero-len");
        chk("zero-len reads", 96'(rd_cnt - rd0), 96'd0);
        chk("zero-len words", 96'(acc_cnt - acc0), 96'd0);
        chk("zero-len done latency", 96'(nt_cyc), 96'(acc_cyc));

        // Backpressure: stall 10 cycles after first valid; reads cap at depth.
        out_ready = 1'b0;
        nt0 = nt_cnt; rd0 = rd_cnt; acc0 = acc_cnt;
        do_req(32'h0000_1000, 8, PH_BIASES);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp first valid seen", 96'(out_valid), 96'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp reads capped", 96'(rd_cnt - rd0), 96'(FIFO_DEPTH));
        out_ready = 1'b1;
        wait_done(nt0, 100, "backpressure");
        chk("bp all words", 96'(acc_cnt - acc0), 96'd8);

        // Address wrap and alignment.
        nt0 = nt_cnt;
        do_req(32'hFFFF_FFFE, 2, PH_IMAGES);
        wait_done(nt0, 50, "wrap");

        // req_en while busy is ignored.
        nt0 = nt_cnt; rd0 = rd_cnt;
        do_req(32'h0000_0300, 4, PH_DIMENSIONS);
        req_en = 1'b1; req_addr = 32'h0000_0800; req_len = 16'd7; req_phase = PH_IMAGES;
        @(posedge clk); #1;
        req_en = 1'b0;
        wait_done(nt0, 50, "busy-ignore");
        repeat (5) @(posedge clk);
        #1;
        chk("busy-ignore read count", 96'(rd_cnt - rd0), 96'd4);

        // Abort mid-transfer with reset, then a fresh request completes.
        nt0 = nt_cnt; acc0 = acc_cnt;
        do_req(32'h0000_0400, 6, PH_BIASES);
        n = 0;
        while (acc_cnt - acc0 < 3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached word 3", 96'(acc_cnt - acc0 >= 3), 96'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("abort outputs");
        rst = 1'b0;
        addr_q.delete();
        exp_q.delete();
        rd0 = rd_cnt;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort no done pulse", 96'(nt_cnt), 96'(nt0));
        chk("abort no stray reads", 96'(rd_cnt), 96'(rd0));
        nt0 = nt_cnt;
        do_req(32'h0000_0500, 3, PH_WEIGHTS);
        wait_done(nt0, 50, "after-abort");

`ifdef DMA_RESP_CHECKSUM_EN
        nt0 = nt_cnt;
        do_req(32'h0000_0200, 4, PH_WEIGHTS);
        wait_done(nt0, 50, "checksum");
        chk("checksum value", 96'(csum_at_nt), 96'h5);
        nt0 = nt_cnt;
        do_req(32'h0000_0600, 0, PH_WEIGHTS);
        wait_done(nt0, 10, "checksum zero-len");
        chk("checksum zero-len", 96'(csum_at_nt), 96'h0);
`endif

        chk("scoreboard drained", 96'(exp_q.size()), 96'd0);
        chk("read queue drained", 96'(addr_q.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
